// File: rtl/accelerator_fifo.sv
// accelerator_fifo: single-clock FIFO buffering samples between the router data bus and a DSP accelerator.
// Define ACC_FIFO_LEVEL_EN to expose the registered occupancy on the level port.
module accelerator_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  put_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  get_req,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
`ifdef ACC_FIFO_LEVEL_EN
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   level
`else
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH:0] LP_FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_put_ok;
  logic                  w_get_ok;
  logic [ADDR_WIDTH:0]   w_next_count;

  // A put into a full FIFO is still fine when a get frees a slot on the same edge.
  assign w_get_ok = get_req & ~r_empty;
  assign w_put_ok = put_req & (~r_full | w_get_ok);

  always_comb begin
    w_next_count = r_count;
    if (w_put_ok && !w_get_ok) begin
      w_next_count = r_count + 1'b1;
    end else if (!w_put_ok && w_get_ok) begin
      w_next_count = r_count - 1'b1;
    end
  end

  // Storage is never cleared; writes are blocked during reset.
  always_ff @(posedge clk) begin
    if (!reset && w_put_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_data_valid <= w_get_ok;
      if (w_put_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_get_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      if (put_req && !w_put_ok) begin
        r_overflow <= 1'b1;
      end
      if (get_req && !w_get_ok) begin
        r_underflow <= 1'b1;
      end
      r_count <= w_next_count;
      r_empty <= (w_next_count == '0);
      r_full  <= (w_next_count == LP_FULL_COUNT);
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign empty      = r_empty;
  assign full       = r_full;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

`ifdef ACC_FIFO_LEVEL_EN
  assign level = r_count;
`endif

endmodule

// File: tb/tb_accelerator_fifo.sv
// tb_accelerator_fifo: directed tests for accelerator_fifo with a queue-based reference model.
// Builds with or without ACC_FIFO_LEVEL_EN; level is checked only when the macro is defined.
module tb_accelerator_fifo;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        putReq;
  logic [31:0] dataIn;
  logic        getReq;
  logic [31:0] dataOut;
  logic        dataValid;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
`ifdef ACC_FIFO_LEVEL_EN
  logic [4:0]  level;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  accelerator_fifo #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(4),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .put_req(putReq),
    .data_in(dataIn),
    .get_req(getReq),
    .data_out(dataOut),
    .data_valid(dataValid),
    .empty(empty),
    .full(full),
    .overflow(overflow),
`ifdef ACC_FIFO_LEVEL_EN
    .underflow(underflow),
    .level(level)
`else
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the observable registered outputs.
  logic [31:0] modelQ[$];
  logic [31:0] modelOut;
  logic        modelValid;
  logic        modelOvf;
  logic        modelUnd;
  bit          modelReady = 0;

  always @(posedge clk) begin
    bit canGet;
    bit canPut;
    if (reset) begin
      modelQ.delete();
      modelOut   = 32'h0;
      modelValid = 1'b0;
      modelOvf   = 1'b0;
      modelUnd   = 1'b0;
      modelReady = 1;
    end else begin
      canGet = getReq && (modelQ.size() > 0);
      canPut = putReq && ((modelQ.size() < DEPTH) || canGet);
      modelValid = canGet;
      if (canGet) modelOut = modelQ.pop_front();
      if (canPut) modelQ.push_back(dataIn);
      if (putReq && !canPut) modelOvf = 1'b1;
      if (getReq && !canGet) modelUnd = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle after the first reset, all outputs must match the model.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("cyc_data_valid", {31'b0, dataValid}, {31'b0, modelValid});
      checkOutput("cyc_data_out", dataOut, modelOut);
      checkOutput("cyc_empty", {31'b0, empty}, {31'b0, modelQ.size() == 0});
      checkOutput("cyc_full", {31'b0, full}, {31'b0, modelQ.size() == DEPTH});
      checkOutput("cyc_overflow", {31'b0, overflow}, {31'b0, modelOvf});
      checkOutput("cyc_underflow", {31'b0, underflow}, {31'b0, modelUnd});
`ifdef ACC_FIFO_LEVEL_EN
      checkOutput("cyc_level", {27'b0, level}, 32'(modelQ.size()));
`endif
    end
  end

  // One clock of requests; returns 1 ns after the edge so outputs reflect it.
  task automatic applyStimulus(input logic put, input logic [31:0] data, input logic get);
    putReq = put;
    dataIn = data;
    getReq = get;
    @(posedge clk);
    #1;
    putReq = 1'b0;
    getReq = 1'b0;
    dataIn = 32'h0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fillWith(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, base + 32'(i), 1'b0);
  endtask

  task automatic drainExpect(input string name, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput({name, "_valid"}, {31'b0, dataValid}, 32'h1);
      checkOutput({name, "_data"}, dataOut, base + 32'(i));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    putReq = 1'b0;
    getReq = 1'b0;
    dataIn = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Test 1: reset values, fill 0..15, drain in order.
    checkOutput("t1_reset_empty", {31'b0, empty}, 32'h1);
    checkOutput("t1_reset_full", {31'b0, full}, 32'h0);
    checkOutput("t1_reset_data_out", dataOut, 32'h0);
    checkOutput("t1_reset_valid", {31'b0, dataValid}, 32'h0);
    fillWith(32'h0, 15);
    checkOutput("t1_full_after15", {31'b0, full}, 32'h0);
    fillWith(32'hF, 1);
    checkOutput("t1_full_after16", {31'b0, full}, 32'h1);
    drainExpect("t1_drain", 32'h0, 16);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t1_valid_idle", {31'b0, dataValid}, 32'h0);
    checkOutput("t1_empty_end", {31'b0, empty}, 32'h1);
    checkOutput("t1_overflow", {31'b0, overflow}, 32'h0);
    checkOutput("t1_underflow", {31'b0, underflow}, 32'h0);

    // Test 2: rejected put on a full FIFO.
    resetDut();
    fillWith(32'h200, 16);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
    checkOutput("t2_overflow", {31'b0, overflow}, 32'h1);
    checkOutput("t2_full", {31'b0, full}, 32'h1);
    drainExpect("t2_drain", 32'h200, 16);
    checkOutput("t2_empty_end", {31'b0, empty}, 32'h1);

    // Test 3: simultaneous put and get while full.
    resetDut();
    fillWith(32'h300, 16);
    applyStimulus(1'b1, 32'hAAAA_5555, 1'b1);
    checkOutput("t3_data_out", dataOut, 32'h300);
    checkOutput("t3_valid", {31'b0, dataValid}, 32'h1);
    checkOutput("t3_full", {31'b0, full}, 32'h1);
    checkOutput("t3_overflow", {31'b0, overflow}, 32'h0);
    drainExpect("t3_drain", 32'h301, 15);
    drainExpect("t3_last", 32'hAAAA_5555, 1);
    checkOutput("t3_empty_end", {31'b0, empty}, 32'h1);

    // Test 4: simultaneous put and get while empty.
    resetDut();
    applyStimulus(1'b1, 32'h1234_5678, 1'b1);
    checkOutput("t4_underflow", {31'b0, underflow}, 32'h1);
    checkOutput("t4_valid", {31'b0, dataValid}, 32'h0);
    checkOutput("t4_empty", {31'b0, empty}, 32'h0);
`ifdef ACC_FIFO_LEVEL_EN
    checkOutput("t4_level", {27'b0, level}, 32'h1);
`endif
    drainExpect("t4_get", 32'h1234_5678, 1);
    checkOutput("t4_empty_end", {31'b0, empty}, 32'h1);

    // Test 5: pointer wrap keeps FIFO order.
    resetDut();
    fillWith(32'h0, 10);
    drainExpect("t5_first", 32'h0, 10);
    fillWith(32'h100, 12);
    drainExpect("t5_wrap", 32'h100, 12);
    checkOutput("t5_empty_end", {31'b0, empty}, 32'h1);

    // Test 6: reset mid-operation with requests held high.
    resetDut();
    fillWith(32'h500, 5);
    reset  = 1'b1;
    putReq = 1'b1;
    getReq = 1'b1;
    dataIn = 32'h5555_0000;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    putReq = 1'b0;
    getReq = 1'b0;
    checkOutput("t6_empty", {31'b0, empty}, 32'h1);
    checkOutput("t6_full", {31'b0, full}, 32'h0);
    checkOutput("t6_data_out", dataOut, 32'h0);
    checkOutput("t6_valid", {31'b0, dataValid}, 32'h0);
    checkOutput("t6_overflow", {31'b0, overflow}, 32'h0);
    checkOutput("t6_underflow", {31'b0, underflow}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t6_get_underflow", {31'b0, underflow}, 32'h1);
    checkOutput("t6_get_valid", {31'b0, dataValid}, 32'h0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/accelerator_fifo.md
Name: accelerator_fifo

Overview:
- Synchronous FIFO that buffers 32-bit samples between the router data bus and one DSP accelerator (FFT, FIR or IIR).
- One instance is used per direction per accelerator: a to-accelerator FIFO and a from-accelerator FIFO.
- It accepts put/get requests from the router's data bus controller and returns the empty/full status that drives the controller's transfer decisions.
- The router side and the accelerator side share one clock.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 4, pointer width. DEPTH = 2**ADDR_WIDTH. Legal values are 2..8.
- DEPTH, 16, number of entries. Must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- put_req  input  1  write request; data_in is captured when accepted.
- data_in  input  DATA_WIDTH  write data.
- get_req  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- data_valid  output  1  one-cycle pulse; data_out holds a newly read word.
- empty  output  1  FIFO holds 0 words.
- full  output  1  FIFO holds DEPTH words.
- overflow  output  1  sticky: a put was rejected.
- underflow  output  1  sticky: a get was rejected.
- level  output  ADDR_WIDTH+1  occupancy. Present only with ACC_FIFO_LEVEL_EN.

Behaviour:
- Single clock domain. reset is synchronous and active-high; all state changes on the rising edge of clk.
- Reset values, sampled at the edge where reset=1:
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, data_valid=0.
  - empty=1, full=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
- Reset mid-operation: all in-flight transfers are discarded. Requests in the reset cycle are ignored, and reset takes priority over every other event.
- Accept rules, evaluated each cycle against the registered flags:
  - put_ok = put_req & (~full | get_ok).
  - get_ok = get_req & ~empty.
- Put accepted: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (natural wrap of ADDR_WIDTH bits).
- Get accepted: data_out <= mem[rd_ptr]; data_valid <= 1 the next cycle; rd_ptr increments modulo DEPTH.
  - Read latency is 1 cycle.
  - No fall-through: a word written in cycle N is first readable by a get in cycle N+1.
- data_valid is 0 in every cycle that follows no accepted get. data_out holds its last value otherwise.
- count update:
  - +1 on put only.
  - -1 on get only.
  - Unchanged on both or neither.
  - Width is ADDR_WIDTH+1, so it reaches DEPTH without wrap.
- empty and full are registered. They are recomputed from the next count on the same edge:
  - empty = (next_count == 0).
  - full = (next_count == DEPTH).
- Boundary conditions:
  - Full, put only: rejected. No write, pointers unchanged. overflow <= 1.
  - Full, put and get together: both accepted. count stays DEPTH, full stays 1.
  - Empty, get only: rejected. data_valid stays 0, data_out unchanged. underflow <= 1.
  - Empty, put and get together: put accepted, get rejected, underflow <= 1. Next cycle count=1, empty=0.
  - Pointer wrap: after DEPTH accepted puts, wr_ptr returns to 0. Ordering is strict FIFO across the wrap.
- overflow and underflow clear only on reset.
- The controller is required to honour the flags. The sticky bits exist for verification and debug.

Optional Feature:
- Macro: ACC_FIFO_LEVEL_EN.
- Defined:
  - The level port exists and equals the registered count.
  - Reset value is 0.
  - Updates on the same edge as empty/full.
- Undefined:
  - The level port is absent from the port list.
  - count stays internal.
  - All other behaviour is identical.

Test Plan:
1. Reset, then 16 puts with data_in = 0x0000_0000..0x0000_000F, then 16 gets.
   - full=1 after the 16th put edge.
   - data_out = 0x0..0xF in order, each with a data_valid pulse one cycle after its get.
   - empty=1 at the end; overflow=0, underflow=0.
2. Fill to 16, then a put of 0xDEAD_BEEF.
   - overflow=1, full stays 1.
   - A subsequent 16-get drain never returns 0xDEAD_BEEF.
3. Fill to 16, then one cycle of put=0xAAAA_5555 with get.
   - data_out = first word written; full stays 1; overflow=0.
   - After draining, 0xAAAA_5555 is the last word out.
4. Empty FIFO, one cycle of put=0x1234_5678 with get.
   - underflow=1, data_valid=0.
   - Next cycle empty=0, level=1 when ACC_FIFO_LEVEL_EN is defined.
   - A following get returns 0x1234_5678.
5. 10 puts, 10 gets, then 12 puts of 0x100..0x10B (wr_ptr wraps), then 12 gets.
   - Output is 0x100..0x10B in order; empty=1 at the end.
6. 5 puts, then reset for 1 cycle with put_req and get_req held high.
   - After reset: empty=1, full=0, data_out=0, data_valid=0, sticky flags 0.
   - A get in the next cycle sets underflow=1.
